// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer driving a word memory, with read-modify-write for byte stores.
// Define LSU_ALIGN_CHECK_EN to reject unsupported widths and misaligned word accesses.
module lsu_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_width,
  input  logic              i_req_zext,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic [1:0]        o_align_tail,
  output logic [1:0]        o_align_width,
  output logic              o_align_zext,
  output logic [31:0]       o_align_word,
  output logic [31:0]       o_align_wval,
  input  logic [31:0]       i_align_rdata,
  input  logic [31:0]       i_align_merged
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t              r_state;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-3:0]   r_addr;
  logic [1:0]          w_width;
  logic [1:0]          w_tail;
  logic                w_err;
`ifdef LSU_ALIGN_CHECK_EN
  assign w_width = i_req_width;
  assign w_tail  = i_req_addr[1:0];
  assign w_err   = !i_req_width[0] || (i_req_width[1] && i_req_addr[1:0] != 2'b00);
`else
  // unsupported widths degrade to a word access, which is always word-aligned
  assign w_width = i_req_width == 2'b01 ? 2'b01 : 2'b11;
  assign w_tail  = w_width == 2'b11 ? 2'b00 : i_req_addr[1:0];
  assign w_err   = 1'b0;
`endif
  assign o_req_ready  = r_state == IDLE;
  assign o_resp_valid = r_state == RESP;
  assign o_resp_err   = o_resp_valid && r_err;
  assign o_resp_rdata = (o_resp_valid && !r_we && !r_err) ? i_align_rdata : '0;
  assign o_mem_req    = r_state == RD || r_state == WR;
  assign o_mem_we     = r_state == WR;
  assign o_mem_addr   = {r_addr, 2'b00};
  assign o_mem_wdata  = r_state == WR ? i_align_merged : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_err         <= 1'b0;
      r_addr        <= '0;
      o_align_tail  <= '0;
      o_align_width <= '0;
      o_align_zext  <= 1'b0;
      o_align_word  <= '0;
      o_align_wval  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_we          <= i_req_we;
          r_err         <= w_err;
          r_addr        <= i_req_addr[ADDR_W-1:2];
          o_align_tail  <= w_tail;
          o_align_width <= w_width;
          o_align_zext  <= i_req_zext;
          o_align_wval  <= i_req_wdata;
          r_state       <= w_err ? RESP : (i_req_we && w_width == 2'b11) ? WR : RD;
        end
        RD: if (i_mem_ack) begin
          o_align_word <= i_mem_rdata;
          r_state      <= r_we ? WR : RESP;
        end
        WR: if (i_mem_ack) r_state <= RESP;
        RESP: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: table-driven and randomized checks of lsu_seq against a word memory and lane-level model.
module tb_lsu_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 0, req_ready, req_we = 0, req_zext = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_width = 0;
  logic        resp_valid, resp_err, mem_req, mem_we, align_zext;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, align_word, align_wval, align_rdata, align_merged;
  logic        mem_ack = 0, stray = 0;
  logic [31:0] mem_rdata = 0;
  logic [1:0]  align_tail, align_width;
  logic [31:0] mem [256];
  int          wait_n = 0, cnt = 0, total = 0, bad = 0;
  bit          rnd = 0;

  always #5 clk = ~clk;

  lsu_seq #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_width(req_width), .i_req_zext(req_zext),
    .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_resp_err(resp_err), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_align_tail(align_tail), .o_align_width(align_width), .o_align_zext(align_zext),
    .o_align_word(align_word), .o_align_wval(align_wval), .i_align_rdata(align_rdata),
    .i_align_merged(align_merged));

  function automatic logic [31:0] f_align(logic [31:0] w, logic [1:0] t, logic [1:0] wd, logic z);
    logic [7:0] b = 8'(w >> (8 * t));
    return wd == 2'b01 ? (z ? {24'h0, b} : {{24{b[7]}}, b}) : w;
  endfunction
  function automatic logic [31:0] f_merge(logic [31:0] w, logic [1:0] t, logic [1:0] wd, logic [31:0] v);
    return wd == 2'b01 ? ((w & ~(32'hff << (8 * t))) | ({24'h0, v[7:0]} << (8 * t))) : v;
  endfunction
  assign align_rdata  = f_align(align_word, align_tail, align_width, align_zext);
  assign align_merged = f_merge(align_word, align_tail, align_width, align_wval);

  // memory responder: ack after wait_n request cycles; writes land when ack is raised
  always @(negedge clk) begin
    if (!rst_n || !mem_req) begin
      mem_ack = stray;
      cnt = 0;
    end else begin
      mem_rdata = mem[mem_addr[9:2]];
      if (cnt >= wait_n) begin
        mem_ack = 1;
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        cnt = 0;
        if (rnd) wait_n = $urandom_range(0, 3);
      end else begin
        mem_ack = 0;
        cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [1:0] w, input logic z,
                     input logic [31:0] wd, output int lat, output int first_req, output int nrd,
                     output logic [31:0] rdata, output logic err, output logic [31:0] wcap,
                     output logic [31:0] acap, output logic unstable);
    logic pv_req = 0, pv_ack = 0, pv_we = 0;
    logic [31:0] pv_a = 0, pv_d = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_width = w; req_zext = z; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
    lat = -1; first_req = -1; nrd = 0; rdata = 0; err = 0; wcap = 0; acap = 0; unstable = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (first_req < 0) first_req = k;
        if (!mem_we) nrd++;
        acap = mem_addr;
        if (mem_we && mem_ack) wcap = mem_wdata;
        if (pv_req && !pv_ack && (mem_addr !== pv_a || mem_we !== pv_we || mem_wdata !== pv_d)) unstable = 1;
      end
      pv_req = mem_req; pv_ack = mem_ack; pv_we = mem_we; pv_a = mem_addr; pv_d = mem_wdata;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout: no resp_valid within 40 cycles, required one");
    end
  endtask

  typedef struct {
    logic we; logic [31:0] addr; logic [1:0] w; logic z; logic [31:0] wd; logic [31:0] mword;
    int wt; logic [31:0] erd; logic [31:0] ewd; int elat; logic eerr; int enrd; logic [31:0] emem;
  } vec_t;

  initial begin
    vec_t v[$];
    int lat, fr, nrd;
    logic [31:0] rd, wc, ac, gold, exp_mem, exp_rd;
    logic er, un, e_err, e_byte;
    logic [7:0] lanes [4];
    v.push_back('{0, 32'h100, 2'b11, 0, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 0, 4, 0, 3, 32'hDEADBEEF});
    v.push_back('{0, 32'h103, 2'b01, 0, 0, 32'h80123456, 0, 32'hFFFFFF80, 0, 2, 0, 1, 32'h80123456});
    v.push_back('{0, 32'h103, 2'b01, 1, 0, 32'h80123456, 0, 32'h00000080, 0, 2, 0, 1, 32'h80123456});
    v.push_back('{1, 32'h201, 2'b01, 0, 32'h000000AB, 32'h11223344, 0, 0, 32'h1122AB44, 3, 0, 1, 32'h1122AB44});
    v.push_back('{1, 32'h300, 2'b11, 0, 32'hCAFEF00D, 32'h0, 0, 0, 32'hCAFEF00D, 2, 0, 0, 32'hCAFEF00D});
    v.push_back('{0, 32'h042, 2'b01, 0, 0, 32'h00FF7F00, 1, 32'hFFFFFFFF, 0, 3, 0, 2, 32'h00FF7F00});
    v.push_back('{1, 32'h0C3, 2'b01, 0, 32'h7777775A, 32'h01020304, 1, 0, 32'h5A020304, 5, 0, 2, 32'h5A020304});
`ifdef LSU_ALIGN_CHECK_EN
    v.push_back('{0, 32'h302, 2'b11, 0, 0, 32'h55667788, 1, 0, 0, 1, 1, 0, 32'h55667788});
    v.push_back('{0, 32'h011, 2'b00, 0, 0, 32'hA1B2C3D4, 0, 0, 0, 1, 1, 0, 32'hA1B2C3D4});
    v.push_back('{1, 32'h020, 2'b10, 0, 32'h1, 32'h0BADF00D, 0, 0, 0, 1, 1, 0, 32'h0BADF00D});
`else
    v.push_back('{0, 32'h302, 2'b11, 0, 0, 32'h55667788, 1, 32'h55667788, 0, 3, 0, 2, 32'h55667788});
    v.push_back('{0, 32'h011, 2'b00, 0, 0, 32'hA1B2C3D4, 0, 32'hA1B2C3D4, 0, 2, 0, 1, 32'hA1B2C3D4});
    v.push_back('{1, 32'h020, 2'b10, 0, 32'h1, 32'h0BADF00D, 0, 0, 32'h1, 2, 0, 0, 32'h1});
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;
    #12;
    chk("rst_ready", {31'h0, req_ready}, 1);
    chk("rst_outs", {resp_valid, resp_err, mem_req, mem_we}, 0);
    chk("rst_data", resp_rdata | mem_addr | mem_wdata | align_word | align_wval, 0);
    chk("rst_align", {align_tail, align_width, align_zext}, 0);
    @(negedge clk) rst_n = 1;
    // stray ack while idle must be ignored
    stray = 1;
    @(negedge clk);
    stray = 0;
    @(negedge clk);
    #1;
    chk("stray_idle", {req_ready, mem_req, resp_valid}, 3'b100);
    foreach (v[i]) begin
      mem[v[i].addr[9:2]] = v[i].mword;
      wait_n = v[i].wt;
      run(v[i].we, v[i].addr, v[i].w, v[i].z, v[i].wd, lat, fr, nrd, rd, er, wc, ac, un);
      chk($sformatf("v%0d_lat", i), lat, v[i].elat);
      chk($sformatf("v%0d_rdata", i), rd, v[i].erd);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, v[i].eerr});
      chk($sformatf("v%0d_first_req", i), fr, v[i].eerr ? -1 : 1);
      chk($sformatf("v%0d_rd_cycles", i), nrd, v[i].enrd);
      chk($sformatf("v%0d_addr", i), ac, v[i].eerr ? 0 : {v[i].addr[31:2], 2'b00});
      if (v[i].we) chk($sformatf("v%0d_wdata", i), wc, v[i].ewd);
      chk($sformatf("v%0d_mem", i), mem[v[i].addr[9:2]], v[i].emem);
      chk($sformatf("v%0d_stable", i), {31'h0, un}, 0);
    end
    // reset during a WR wait abandons the access
    mem[20] = 32'h12345678;
    wait_n = 8;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h50; req_width = 2'b11; req_wdata = 32'h99;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_pre_wr", {31'h0, mem_req && mem_we}, 1);
    #2 rst_n = 0;
    #1 chk("rst_midreq", {31'h0, mem_req}, 0);
    chk("rst_midready", {31'h0, req_ready}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    er = 0;
    repeat (3) begin
      @(negedge clk);
      #1 if (resp_valid || mem_req) er = 1;
    end
    chk("rst_no_resp", {31'h0, er}, 0);
    chk("rst_ready_after", {31'h0, req_ready}, 1);
    chk("rst_mem_kept", mem[20], 32'h12345678);
    wait_n = 0;
    run(0, 32'h50, 2'b11, 0, 0, lat, fr, nrd, rd, er, wc, ac, un);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_rdata", rd, 32'h12345678);
    // randomized traffic against a byte-lane model of memory
    rnd = 1;
    wait_n = $urandom_range(0, 3);
    for (int n = 0; n < 200; n++) begin
      logic rwe, rz;
      logic [31:0] ra, rwd;
      logic [1:0] rw;
      rwe = 1'($urandom); rz = 1'($urandom); rw = 2'($urandom);
      ra = $urandom_range(0, 1023); rwd = $urandom;
      gold = mem[ra[9:2]];
      for (int j = 0; j < 4; j++) lanes[j] = gold[8*j +: 8];
`ifdef LSU_ALIGN_CHECK_EN
      e_err = (rw == 2'b00) || (rw == 2'b10) || (rw == 2'b11 && ra[1:0] != 0);
`else
      e_err = 0;
`endif
      e_byte = rw == 2'b01;
      exp_rd = 0;
      exp_mem = gold;
      if (!e_err && !rwe)
        exp_rd = e_byte ? (rz ? {24'h0, lanes[ra[1:0]]} : {{24{lanes[ra[1:0]][7]}}, lanes[ra[1:0]]}) : gold;
      if (!e_err && rwe) begin
        if (e_byte) begin
          lanes[ra[1:0]] = rwd[7:0];
          exp_mem = {lanes[3], lanes[2], lanes[1], lanes[0]};
        end else exp_mem = rwd;
      end
      run(rwe, ra, rw, rz, rwd, lat, fr, nrd, rd, er, wc, ac, un);
      chk($sformatf("r%0d_rdata", n), rd, exp_rd);
      chk($sformatf("r%0d_err", n), {31'h0, er}, {31'h0, e_err});
      chk($sformatf("r%0d_mem", n), mem[ra[9:2]], exp_mem);
      chk($sformatf("r%0d_first_req", n), fr, e_err ? -1 : 1);
      chk($sformatf("r%0d_stable", n), {31'h0, un}, 0);
    end
    rnd = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_seq.md
# lsu_seq

Multi-cycle load/store sequencer between the execute stage and a handshaked, word-organised data memory. Accepts one load or store per transaction and issues word-aligned memory reads/writes. It drives the byte-lane read aligner and write merger with the fetched memory word, and performs read-modify-write for sub-word stores. The aligner's extended result is returned on the response port.

## Interface
- ADDR_W, 32, byte address width; memory address is ADDR_W bits with [1:0] forced to 0
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_width  in  2  2'b01 byte, 2'b11 word; 2'b00/2'b10 unsupported
- req_zext  in  1  load zero-extend (1) / sign-extend (0)
- req_wdata  in  32  store data, byte stores use [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (align_rdata) while resp_valid && load, else 0
- resp_err  out  1  valid with resp_valid; request rejected
- mem_req  out  1  memory access request
- mem_we  out  1  write when 1
- mem_addr  out  ADDR_W  {req_addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  write word
- mem_ack  in  1  access completes on this edge when mem_req high
- mem_rdata  in  32  read word, valid when mem_ack
- align_tail  out  2  latched req_addr[1:0]
- align_width  out  2  latched req_width
- align_zext  out  1  latched req_zext
- align_word  out  32  registered memory word (aligner inval / merger inmem)
- align_wval  out  32  latched req_wdata (merger inval)
- align_rdata  in  32  aligner result
- align_merged  in  32  merger result

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/width/zext/we/wdata into the request registers; go to:
  - RD for a load or a byte store
  - WR for a word store (no read needed)
  - RESP with error for a rejected request (see Configuration)
- RD: mem_req=1, mem_we=0. Holds until mem_ack. On ack, align_word <= mem_rdata; load -> RESP, byte store -> WR.
- WR: mem_req=1, mem_we=1, mem_wdata=align_merged. Holds until mem_ack, then -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- mem_addr, mem_we and mem_wdata are stable while mem_req is high and the access is unacked.
- align_* are stable from the cycle after acceptance until the cycle after RESP.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, align_* all 0.
- Async reset mid-transaction returns to IDLE immediately and drops mem_req. The in-flight access is abandoned and no response is issued.
- A mem_ack arriving while mem_req=0 is ignored.

## Timing
- Acceptance edge T0. mem_req rises in cycle T0+1.
- Load with ack at the first opportunity (T1): resp_valid in T2, req_ready in T3. Each wait cycle adds one.
- Byte store: RD ack at T1, WR from T2, ack at T2, resp_valid in T3.
- Word store: WR from T1, ack at T1, resp_valid in T2.
- Rejected request: resp_valid with resp_err=1 in T1; no mem_req ever asserted.
- mem_wdata in WR is combinational from align_merged, whose inputs are registered; there is no in-cycle dependency on mem_rdata.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - These requests go IDLE->RESP with resp_err=1, resp_rdata=0, and no memory access: req_width 2'b00/2'b10, and width 2'b11 with req_addr[1:0]≠0.
- Undefined:
  - resp_err is tied 0.
  - Width 2'b11 forces align_tail to 2'b00.
  - Widths 2'b00/2'b10 are latched as 2'b11.
  - Every request performs the word-sized access.

## Test plan
- Load word, addr 0x100, mem_rdata 0xDEADBEEF, ack after 2 wait cycles -> mem_addr 0x100, resp_rdata 0xDEADBEEF, resp_valid at T4.
- Load byte sign-extended, addr 0x103, mem_rdata 0x80123456 -> align_tail 2'b11, resp_rdata 0xFFFFFF80; same with zext=1 -> 0x00000080.
- Byte store 0xAB to addr 0x201, memory word 0x11223344 -> RD then WR at 0x200, mem_wdata 0x1122AB44, resp_valid T3.
- Word store 0xCAFEF00D to 0x300 -> no read cycle, single WR, mem_wdata 0xCAFEF00D, resp_valid T2.
- Word load addr 0x302 with LSU_ALIGN_CHECK_EN -> resp_err=1 at T1, mem_req never high. Without the macro -> mem_addr 0x300, word returned.
- Assert rst_n low during WR wait -> mem_req 0 immediately, no resp_valid, req_ready=1 after release; a new load then completes normally.
